// File: rtl/return_write_arbiter.sv
// Round-robin arbiter sharing one AXI-4 write master between two burst writers.
// A grant covers a whole burst (AW accept through B response); attributes are fixed.
module return_write_arbiter #(
  parameter int MEM_ADDR_WIDTH = 64,
  parameter int MEM_DATA_WIDTH = 512
) (
  input  logic                        system_clk,
  input  logic                        rst_n,

  input  logic [MEM_ADDR_WIDTH-1:0]   s0_awaddr,
  input  logic [7:0]                  s0_awlen,
  input  logic                        s0_awvalid,
  output logic                        s0_awready,
  input  logic [MEM_DATA_WIDTH-1:0]   s0_wdata,
  input  logic                        s0_wlast,
  input  logic                        s0_wvalid,
  output logic                        s0_wready,
  output logic                        s0_bvalid,
  output logic [1:0]                  s0_bresp,
  input  logic                        s0_bready,

  input  logic [MEM_ADDR_WIDTH-1:0]   s1_awaddr,
  input  logic [7:0]                  s1_awlen,
  input  logic                        s1_awvalid,
  output logic                        s1_awready,
  input  logic [MEM_DATA_WIDTH-1:0]   s1_wdata,
  input  logic                        s1_wlast,
  input  logic                        s1_wvalid,
  output logic                        s1_wready,
  output logic                        s1_bvalid,
  output logic [1:0]                  s1_bresp,
  input  logic                        s1_bready,

  output logic [MEM_ADDR_WIDTH-1:0]   m00_axi_awaddr,
  output logic [7:0]                  m00_axi_awlen,
  output logic                        m00_axi_awvalid,
  input  logic                        m00_axi_awready,
  output logic [2:0]                  m00_axi_awsize,
  output logic [1:0]                  m00_axi_awburst,
  output logic                        m00_axi_awlock,
  output logic [3:0]                  m00_axi_awcache,
  output logic [2:0]                  m00_axi_awprot,
  output logic [3:0]                  m00_axi_awqos,
  output logic [MEM_DATA_WIDTH-1:0]   m00_axi_wdata,
  output logic [MEM_DATA_WIDTH/8-1:0] m00_axi_wstrb,
  output logic                        m00_axi_wlast,
  output logic                        m00_axi_wvalid,
  input  logic                        m00_axi_wready,
  input  logic [1:0]                  m00_axi_bresp,
  input  logic                        m00_axi_bvalid,
  output logic                        m00_axi_bready,

  output logic                        grant_id,
  output logic                        busy,
  output logic                        protocol_error
);

  // Handshake rule on every channel: a transfer happens on a rising edge
  // where valid and ready are both high; valid never waits on ready.
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t     state_q;
  logic       grant_q;
  logic       ptr_q;
  logic       err_q;
  logic [7:0] len_q;
  logic [7:0] cnt_q;

  logic       sel_awvalid, sel_wvalid, sel_wlast, sel_bready;
  logic [7:0] sel_awlen;
  logic       aw_hs, w_hs, b_hs;
  logic       arb_pick;

  assign sel_awvalid = grant_q ? s1_awvalid : s0_awvalid;
  assign sel_awlen   = grant_q ? s1_awlen   : s0_awlen;
  assign sel_wvalid  = grant_q ? s1_wvalid  : s0_wvalid;
  assign sel_wlast   = grant_q ? s1_wlast   : s0_wlast;
  assign sel_bready  = grant_q ? s1_bready  : s0_bready;

  // Only one requester: take it. Both: the pointer decides.
  assign arb_pick = (s0_awvalid & s1_awvalid) ? ptr_q : s1_awvalid;

  assign m00_axi_awaddr  = grant_q ? s1_awaddr : s0_awaddr;
  assign m00_axi_awlen   = sel_awlen;
  assign m00_axi_awvalid = (state_q == S_ADDR) & sel_awvalid;
  assign m00_axi_wdata   = grant_q ? s1_wdata : s0_wdata;
  assign m00_axi_wlast   = (state_q == S_DATA) & sel_wlast;
  assign m00_axi_wvalid  = (state_q == S_DATA) & sel_wvalid;
  assign m00_axi_bready  = (state_q == S_RESP) & sel_bready;

  assign m00_axi_awsize  = 3'b110;
  assign m00_axi_awburst = 2'b01;
  assign m00_axi_awlock  = 1'b0;
  assign m00_axi_awcache = 4'b0000;
  assign m00_axi_awprot  = 3'b000;
  assign m00_axi_awqos   = 4'b0000;
  assign m00_axi_wstrb   = '1;

  assign aw_hs = m00_axi_awvalid & m00_axi_awready;
  assign w_hs  = m00_axi_wvalid  & m00_axi_wready;
  assign b_hs  = m00_axi_bvalid  & m00_axi_bready;

  assign s0_awready = (state_q == S_ADDR) & ~grant_q & m00_axi_awready;
  assign s1_awready = (state_q == S_ADDR) &  grant_q & m00_axi_awready;
  assign s0_wready  = (state_q == S_DATA) & ~grant_q & m00_axi_wready;
  assign s1_wready  = (state_q == S_DATA) &  grant_q & m00_axi_wready;
  assign s0_bvalid  = (state_q == S_RESP) & ~grant_q & m00_axi_bvalid;
  assign s1_bvalid  = (state_q == S_RESP) &  grant_q & m00_axi_bvalid;
  assign s0_bresp   = ((state_q == S_RESP) & ~grant_q) ? m00_axi_bresp : 2'b00;
  assign s1_bresp   = ((state_q == S_RESP) &  grant_q) ? m00_axi_bresp : 2'b00;

  assign grant_id       = grant_q;
  assign busy           = (state_q != S_IDLE);
  assign protocol_error = err_q;

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= 1'b0;
      ptr_q   <= 1'b0;
      err_q   <= 1'b0;
      len_q   <= 8'd0;
      cnt_q   <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (s0_awvalid | s1_awvalid) begin
            grant_q <= arb_pick;
            state_q <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (aw_hs) begin
            len_q   <= sel_awlen;
            cnt_q   <= 8'd0;
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_hs) begin
            cnt_q <= cnt_q + 8'd1;
            // cnt_q holds the zero-based index of the beat being accepted
            if (sel_wlast) begin
              if (cnt_q != len_q) err_q <= 1'b1;
              state_q <= S_RESP;
            end else if (cnt_q == len_q) begin
              err_q <= 1'b1;
            end
          end
        end
        S_RESP: begin
          if (b_hs) begin
            ptr_q   <= ~grant_q;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
